// File: rtl/mux_pkg.sv
// Shared definitions for the registered K:1 mux: select-width helper,
// skid-buffer state encoding and the default reset value.
package mux_pkg;

    localparam logic [31:0] DEF_RST_VAL = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic int unsigned sel_width(input int unsigned k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational K:1 selector, binary select by default or one-hot select
// when MUX_N_REG_ONEHOT_EN is defined; reports illegal selects.
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int unsigned N             = 32,
    parameter int unsigned K             = 4,
    parameter logic [N-1:0] RST_VAL      = N'(DEF_RST_VAL),
    localparam int unsigned SW           = sel_width(K),
`ifdef MUX_N_REG_ONEHOT_EN
    localparam int unsigned SELW         = K
`else
    localparam int unsigned SELW         = SW
`endif
) (
    input  logic [K*N-1:0]  in_data_i,
    input  logic [SELW-1:0] sel_i,
    output logic [N-1:0]    data_o,
    output logic            illegal_o
);

`ifdef MUX_N_REG_ONEHOT_EN
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (sel_i[i]) data_o = data_o | in_data_i[i*N +: N];
        end
        // An empty select yields the reset value rather than zero.
        if (sel_i == '0) data_o = RST_VAL;
        illegal_o = ($countones(sel_i) != 1);
    end
`else
    always_comb begin
        data_o    = RST_VAL;
        illegal_o = 1'b1;
        for (int unsigned i = 0; i < K; i++) begin
            if (sel_i == SW'(i)) begin
                data_o    = in_data_i[i*N +: N];
                illegal_o = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/mux_n_reg.sv
// K:1 mux with registered output, two-entry skid buffer for valid/ready flow
// control and a sticky illegal-select flag. Optional macro: MUX_N_REG_ONEHOT_EN.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int unsigned N             = 32,
    parameter int unsigned K             = 4,
    parameter logic [N-1:0] RST_VAL      = N'(DEF_RST_VAL),
    localparam int unsigned SW           = sel_width(K),
`ifdef MUX_N_REG_ONEHOT_EN
    localparam int unsigned SELW         = K
`else
    localparam int unsigned SELW         = SW
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [K*N-1:0]  in_data,
    input  logic [SELW-1:0] sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err,
    input  logic            err_clr
);

    state_t         state_q, state_d;
    logic [N-1:0]   main_q, main_d;
    logic [N-1:0]   skid_q, skid_d;
    logic           rdy_q;
    logic           err_q, err_d;
    logic [N-1:0]   sel_data;
    logic           sel_ill;
    logic           accept;
    logic           xfer;

    mux_n_sel #(
        .N       (N),
        .K       (K),
        .RST_VAL (RST_VAL)
    ) u_sel (
        .in_data_i (in_data),
        .sel_i     (sel),
        .data_o    (sel_data),
        .illegal_o (sel_ill)
    );

    assign accept = in_valid && rdy_q;
    assign xfer   = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = sel_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    main_d = sel_data;
                end else if (accept) begin
                    skid_d  = sel_data;
                    state_d = FULL;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the skid-to-main move can occur.
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Set has priority over a coincident clear.
        err_d = (err_q && !err_clr) || (accept && sel_ill);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != FULL);
            err_q   <= err_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = (state_q != EMPTY);
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Self-checking bench for mux_n_reg: directed steps plus a random stream,
// with a scoreboard queue tracking accepted words in order.
module tb_mux_n_reg;

    localparam int unsigned N   = 32;
    localparam int unsigned K   = 4;
    localparam int unsigned KB  = 3;
    localparam logic [31:0] RVB = 32'hDEAD_BEEF;
`ifdef MUX_N_REG_ONEHOT_EN
    localparam int unsigned SA = K;
    localparam int unsigned SB = KB;
`else
    localparam int unsigned SA = 2;
    localparam int unsigned SB = 2;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [K*N-1:0]  in_data = '0;
    logic [SA-1:0]   sel = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            sel_err;
    logic            err_clr = 1'b0;

    logic [KB*N-1:0] b_in_data = '0;
    logic [SB-1:0]   b_sel = '0;
    logic            b_in_valid = 1'b0;
    logic            b_in_ready;
    logic [N-1:0]    b_out_data;
    logic            b_out_valid;
    logic            b_out_ready = 1'b0;
    logic            b_sel_err;
    logic            b_err_clr = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [N-1:0] sb[$];
    logic         stall_q = 1'b0;
    logic [N-1:0] stall_data = '0;

    always #5 clk = ~clk;

    mux_n_reg #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
        .err_clr(err_clr)
    );

    mux_n_reg #(.N(N), .K(KB), .RST_VAL(RVB)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err),
        .err_clr(b_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SA-1:0] enc(input int unsigned i);
`ifdef MUX_N_REG_ONEHOT_EN
        return SA'(1) << i;
`else
        return SA'(i);
`endif
    endfunction

    function automatic logic [N-1:0] model(input logic [K*N-1:0] d, input logic [SA-1:0] s);
        logic [N-1:0] w [K];
        logic [N-1:0] r;
        for (int i = 0; i < K; i++) w[i] = d[i*N +: N];
`ifdef MUX_N_REG_ONEHOT_EN
        r = '0;
        for (int i = 0; i < K; i++) if (s[i]) r = r | w[i];
        if (s == '0) r = '0;
`else
        r = w[s];
`endif
        return r;
    endfunction

    // Scoreboard and hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_nonempty", 32'(sb.size()), 32'd1);
                else chk("sb_data", out_data, sb.pop_front());
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            if (in_valid && in_ready) sb.push_back(model(in_data, sel));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Asynchronous reset
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_b_out_data", b_out_data, RVB);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        cyc();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Streaming
        in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = enc(2);
        cyc();
        sel = enc(0);
        chk("str_v0", 32'(out_valid), 32'd1);
        chk("str_d0", out_data, 32'h33);
        chk("str_r0", 32'(in_ready), 32'd1);
        cyc();
        sel = enc(3);
        chk("str_d1", out_data, 32'h11);
        chk("str_r1", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("str_d2", out_data, 32'h44);
        cyc();
        chk("str_empty", 32'(out_valid), 32'd0);
        chk("str_no_err", 32'(sel_err), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = enc(1);
        cyc();
        sel = enc(2);
        chk("bp_r0", 32'(in_ready), 32'd1);
        chk("bp_d0", out_data, 32'h22);
        cyc();
        chk("bp_r1", 32'(in_ready), 32'd0);
        chk("bp_d1", out_data, 32'h22);
        cyc();
        chk("bp_r2", 32'(in_ready), 32'd0);
        chk("bp_d2", out_data, 32'h22);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_d3", out_data, 32'h33);
        chk("bp_v3", 32'(out_valid), 32'd1);
        chk("bp_r3", 32'(in_ready), 32'd1);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

`ifdef MUX_N_REG_ONEHOT_EN
        // One-hot select
        in_valid = 1'b1;
        sel      = 4'b0100;
        cyc();
        in_valid = 1'b0;
        chk("oh_d0", out_data, 32'h33);
        chk("oh_e0", 32'(sel_err), 32'd0);
        in_valid = 1'b1;
        sel      = 4'b0000;
        cyc();
        in_valid = 1'b0;
        chk("oh_d1", out_data, 32'd0);
        chk("oh_e1", 32'(sel_err), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("oh_clr", 32'(sel_err), 32'd0);
        in_valid = 1'b1;
        sel      = 4'b0011;
        cyc();
        in_valid = 1'b0;
        chk("oh_d2", out_data, 32'h33);
        chk("oh_e2", 32'(sel_err), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
`else
        // Illegal select on the K=3 instance
        b_in_data   = {32'h33, 32'h22, 32'h11};
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_sel       = 2'd3;
        cyc();
        b_in_valid = 1'b0;
        chk("ill_v", 32'(b_out_valid), 32'd1);
        chk("ill_d", b_out_data, RVB);
        chk("ill_e", 32'(b_sel_err), 32'd1);
        cyc();
        chk("ill_hold", 32'(b_sel_err), 32'd1);
        b_err_clr = 1'b1;
        cyc();
        b_err_clr = 1'b0;
        chk("ill_clr", 32'(b_sel_err), 32'd0);
        b_in_valid = 1'b1;
        b_sel      = 2'd1;
        cyc();
        chk("leg_d", b_out_data, 32'h22);
        chk("leg_e", 32'(b_sel_err), 32'd0);
        b_sel     = 2'd3;
        b_err_clr = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        b_err_clr  = 1'b0;
        chk("ill_set_wins", 32'(b_sel_err), 32'd1);
`endif

        // Reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = enc(3);
        repeat (2) cyc();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mrst_v", 32'(out_valid), 32'd0);
        chk("mrst_d", out_data, 32'd0);
        chk("mrst_e", 32'(sel_err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc();
        chk("mrst_r", 32'(in_ready), 32'd1);
        chk("mrst_empty", 32'(out_valid), 32'd0);

        // Random stream
        for (int c = 0; c < 10000; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            sel       = enc($urandom_range(0, K - 1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("end_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
